// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multicycle MIPS main controller. Steps each instruction through
//            fetch, decode, execute, memory and writeback. Drives the datapath
//            mux/enable strobes and the 4-bit ALU control code. Memory states
//            wait on a ready handshake that is bounded by a timeout counter.
// Ports    : clk, rst_n (async, active low)
//            i_opcode/i_funct - instruction fields, stable from DECODE on
//            i_zero           - ALU zero flag (BEQ/BNE)
//            i_mem_ready      - memory access completes this cycle
//            o_mem_read/o_mem_write/o_i_or_d/o_ir_write/o_pc_en/o_pc_source
//            o_alu_src_a/o_alu_src_b/o_alu_control
//            o_reg_write/o_reg_dst/o_mem_to_reg - writeback controls
//            o_illegal_op/o_mem_err - one-cycle error pulses
//            o_state          - current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_i_or_d,
  output logic       o_ir_write,
  output logic       o_pc_en,
  output logic [1:0] o_pc_source,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [3:0] o_alu_control,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_illegal_op,
  output logic       o_mem_err,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_SLL = 4'b1000;
  localparam logic [3:0] C_ALU_SRL = 4'b1001;

  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [3:0] w_rtype_alu;
  logic       w_funct_ok;
  logic       w_mem_state;
  logic       w_timeout;

  // R-type function decode. funct is stable until FETCH, so ALU_WB re-decodes
  // the same code EXEC_R used instead of holding it in a register.
  always_comb begin
    w_rtype_alu = C_ALU_ADD;
    w_funct_ok  = 1'b1;
    case (i_funct)
      6'b100000: w_rtype_alu = C_ALU_ADD;
      6'b100010: w_rtype_alu = C_ALU_SUB;
      6'b100100: w_rtype_alu = C_ALU_AND;
      6'b100101: w_rtype_alu = C_ALU_OR;
      6'b101010: w_rtype_alu = C_ALU_SLT;
      6'b000000: w_rtype_alu = C_ALU_SLL;
      6'b000010: w_rtype_alu = C_ALU_SRL;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  // A ready arriving on the last allowed cycle takes priority over the abort.
  assign w_timeout   = w_mem_state && !i_mem_ready && (r_wait_cnt == C_WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Any state change clears the counter, which covers every entry into a
  // memory state; a timeout in FETCH loops back to FETCH and clears too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if ((w_next != r_state) || w_timeout) begin
      r_wait_cnt <= 8'd0;
    end else if (w_mem_state && !i_mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_i_or_d      = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_en       = 1'b0;
    o_pc_source   = 2'b00;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'b00;
    o_alu_control = 4'b0000;
    o_reg_write   = 1'b0;
    o_reg_dst     = 1'b0;
    o_mem_to_reg  = 1'b0;
    o_illegal_op  = 1'b0;
    o_mem_err     = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        o_mem_read    = 1'b1;
        o_alu_src_b   = 2'b01;
        o_alu_control = C_ALU_ADD;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_en    = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          o_mem_err = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target PC + (imm<<2) is precomputed into ALUOut here.
        o_alu_src_b   = 2'b11;
        o_alu_control = C_ALU_ADD;
        case (i_opcode)
          C_OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next = S_EXEC_R;
            end else begin
              o_illegal_op = 1'b1;
              w_next       = S_FETCH;
            end
          end
          C_OP_LW, C_OP_SW:   w_next = S_MEMADR;
          C_OP_BEQ, C_OP_BNE: w_next = S_BRANCH;
          C_OP_ADDI:          w_next = S_ADDI_EX;
          C_OP_J:             w_next = S_JUMP;
          default: begin
            o_illegal_op = 1'b1;
            w_next       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a   = 1'b1;
        o_alu_src_b   = 2'b10;
        o_alu_control = C_ALU_ADD;
        w_next        = (i_opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          o_mem_err = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
        if (i_mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          o_mem_err = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        o_alu_src_a   = 1'b1;
        o_alu_control = w_rtype_alu;
        w_next        = S_ALU_WB;
      end
      S_ALU_WB: begin
        o_reg_write   = 1'b1;
        o_reg_dst     = 1'b1;
        o_alu_control = w_rtype_alu;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a   = 1'b1;
        o_alu_control = C_ALU_SUB;
        o_pc_source   = 2'b01;
        o_pc_en       = ((i_opcode == C_OP_BEQ) && i_zero) ||
                        ((i_opcode == C_OP_BNE) && !i_zero);
        w_next        = S_FETCH;
      end
      S_ADDI_EX: begin
        o_alu_src_a   = 1'b1;
        o_alu_src_b   = 2'b10;
        o_alu_control = C_ALU_ADD;
        w_next        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        o_pc_source = 2'b10;
        o_pc_en     = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Self-checking bench for mips_multicycle_ctrl. Per-cycle expected
//            state/outputs are queued when inputs are driven and compared on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                         S_MEMWR = 4'd6, S_EXEC_R = 4'd7, S_ALU_WB = 4'd8,
                         S_BRANCH = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                         S_JUMP = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111,
                         SRL = 4'b1001, Z4 = 4'b0000;

  typedef struct packed {
    logic       mr, mw, iod, irw, pce;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aluc;
    logic       rw, rd, m2r, ill, merr;
  } outs_t;

  typedef struct packed {
    logic [5:0] op, fn;
    logic       zero, rdy;
    logic [3:0] st;
    logic       pce, irw;
    logic [3:0] aluc;
    logic       ill, merr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op, mem_err;
  logic [3:0] alu_control, state;

  int errors = 0;
  int checks = 0;
  int idx    = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_i_or_d(i_or_d), .o_ir_write(ir_write), .o_pc_en(pc_en),
    .o_pc_source(pc_source), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_control(alu_control), .o_reg_write(reg_write), .o_reg_dst(reg_dst),
    .o_mem_to_reg(mem_to_reg), .o_illegal_op(illegal_op), .o_mem_err(mem_err),
    .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic rdy, input logic [3:0] st,
                              input logic pce, input logic irw, input logic [3:0] aluc,
                              input logic ill, input logic merr);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy; v.st = st;
    v.pce = pce; v.irw = irw; v.aluc = aluc; v.ill = ill; v.merr = merr;
    return v;
  endfunction

  // Unconditional per-state strobes; gated bits, ALU code and pulses come
  // from each vector.
  function automatic outs_t base(input logic [3:0] st);
    outs_t o = '0;
    case (st)
      S_FETCH:   begin o.mr = 1'b1; o.asb = 2'b01; end
      S_DECODE:  o.asb = 2'b11;
      S_MEMADR:  begin o.asa = 1'b1; o.asb = 2'b10; end
      S_MEMRD:   begin o.mr = 1'b1; o.iod = 1'b1; end
      S_MEMWB:   begin o.rw = 1'b1; o.m2r = 1'b1; end
      S_MEMWR:   begin o.mw = 1'b1; o.iod = 1'b1; end
      S_EXEC_R:  o.asa = 1'b1;
      S_ALU_WB:  begin o.rw = 1'b1; o.rd = 1'b1; end
      S_BRANCH:  begin o.asa = 1'b1; o.pcs = 2'b01; end
      S_ADDI_EX: begin o.asa = 1'b1; o.asb = 2'b10; end
      S_ADDI_WB: o.rw = 1'b1;
      S_JUMP:    o.pcs = 2'b10;
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
         alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg, illegal_op, mem_err};
    return a;
  endfunction

  // Called just after a rising edge: drive one cycle of inputs, queue the
  // expectation, and advance to just after the next rising edge.
  task automatic step(input vec_t v);
    opcode = v.op; funct = v.fn; zero = v.zero; mem_ready = v.rdy;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  v;
      outs_t e, a;
      v = exp_q.pop_front();
      e = base(v.st);
      e.pce = v.pce; e.irw = v.irw; e.aluc = v.aluc; e.ill = v.ill; e.merr = v.merr;
      a = actual();
      checks++;
      if (state !== v.st) begin
        errors++;
        $display("FAIL step%0d state: got %0d expected %0d", idx, state, v.st);
      end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d outputs: got %h expected %h", idx, a, e);
      end
      idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main vector table (one entry per cycle)
    tbl.push_back(mk(OP_R,   6'b101010, 0, 1, S_IDLE,    0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_R,   6'b101010, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_R,   6'b101010, 0, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_R,   6'b101010, 0, 1, S_EXEC_R,  0, 0, SLT, 0, 0));
    tbl.push_back(mk(OP_R,   6'b101010, 0, 1, S_ALU_WB,  0, 0, SLT, 0, 0));
    tbl.push_back(mk(OP_R,   6'b000010, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_R,   6'b000010, 0, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_R,   6'b000010, 0, 1, S_EXEC_R,  0, 0, SRL, 0, 0));
    tbl.push_back(mk(OP_R,   6'b000010, 0, 1, S_ALU_WB,  0, 0, SRL, 0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 1, S_MEMADR,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 0, S_MEMRD,   0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 0, S_MEMRD,   0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 0, S_MEMRD,   0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 1, S_MEMRD,   0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_LW,  6'b000000, 0, 1, S_MEMWB,   0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_BEQ, 6'b000000, 1, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_BEQ, 6'b000000, 1, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_BEQ, 6'b000000, 1, 1, S_BRANCH,  1, 0, SUB, 0, 0));
    tbl.push_back(mk(OP_BNE, 6'b000000, 1, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_BNE, 6'b000000, 1, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_BNE, 6'b000000, 1, 1, S_BRANCH,  0, 0, SUB, 0, 0));
    tbl.push_back(mk(OP_ADDI,6'b000000, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_ADDI,6'b000000, 0, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_ADDI,6'b000000, 0, 1, S_ADDI_EX, 0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_ADDI,6'b000000, 0, 1, S_ADDI_WB, 0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_J,   6'b000000, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_J,   6'b000000, 0, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_J,   6'b000000, 0, 1, S_JUMP,    1, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_BAD, 6'b000000, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_BAD, 6'b000000, 0, 1, S_DECODE,  0, 0, ADD, 1, 0));
    tbl.push_back(mk(OP_R,   6'b111111, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_R,   6'b111111, 0, 1, S_DECODE,  0, 0, ADD, 1, 0));
    tbl.push_back(mk(OP_SW,  6'b000000, 0, 0, S_FETCH,   0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_SW,  6'b000000, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));
    tbl.push_back(mk(OP_SW,  6'b000000, 0, 1, S_DECODE,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_SW,  6'b000000, 0, 1, S_MEMADR,  0, 0, ADD, 0, 0));
    tbl.push_back(mk(OP_SW,  6'b000000, 0, 1, S_MEMWR,   0, 0, Z4,  0, 0));
    tbl.push_back(mk(OP_SW,  6'b000000, 0, 1, S_FETCH,   1, 1, ADD, 0, 0));

    // Reset state while rst_n is held low
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE);
    end
    checks++;
    if (actual() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", actual());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // sw with mem_ready stuck low: abort on the 16th MEMWR cycle
    step(mk(OP_SW, 6'b0, 0, 1, S_DECODE, 0, 0, ADD, 0, 0));
    step(mk(OP_SW, 6'b0, 0, 1, S_MEMADR, 0, 0, ADD, 0, 0));
    for (int k = 0; k < 15; k++) step(mk(OP_SW, 6'b0, 0, 0, S_MEMWR, 0, 0, Z4, 0, 0));
    step(mk(OP_SW, 6'b0, 0, 0, S_MEMWR, 0, 0, Z4, 0, 1));
    step(mk(OP_SW, 6'b0, 0, 1, S_FETCH, 1, 1, ADD, 0, 0));

    // Same, but ready arrives on the 16th cycle: normal completion
    step(mk(OP_SW, 6'b0, 0, 1, S_DECODE, 0, 0, ADD, 0, 0));
    step(mk(OP_SW, 6'b0, 0, 1, S_MEMADR, 0, 0, ADD, 0, 0));
    for (int k = 0; k < 15; k++) step(mk(OP_SW, 6'b0, 0, 0, S_MEMWR, 0, 0, Z4, 0, 0));
    step(mk(OP_SW, 6'b0, 0, 1, S_MEMWR, 0, 0, Z4, 0, 0));
    step(mk(OP_LW, 6'b0, 0, 1, S_FETCH, 1, 1, ADD, 0, 0));

    // lw interrupted by reset in MEMRD
    step(mk(OP_LW, 6'b0, 0, 1, S_DECODE, 0, 0, ADD, 0, 0));
    step(mk(OP_LW, 6'b0, 0, 1, S_MEMADR, 0, 0, ADD, 0, 0));
    step(mk(OP_LW, 6'b0, 0, 0, S_MEMRD,  0, 0, Z4,  0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_mem_read: got %b expected 0", mem_read);
    end
    checks++;
    if (state !== S_IDLE) begin
      errors++;
      $display("FAIL async_reset_state: got %0d expected %0d", state, S_IDLE);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(OP_R, 6'b100000, 0, 1, S_IDLE,  0, 0, Z4,  0, 0));
    step(mk(OP_R, 6'b100000, 0, 1, S_FETCH, 1, 1, ADD, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
